// File: rtl/i2c_temp_responder_if.sv
// Bus-side signals of the I2C temperature responder: SCL/SDA, the sampled
// temperature word, and the status/debug outputs back to the controller side.
interface i2c_temp_responder_if;
  logic        SCL;
  logic        SDA_in;
  logic [15:0] Temperature;
  logic        SDA_low;
  logic        Busy;
  logic        ReadDone;
  logic [2:0]  State;

  modport master (
    output SCL, SDA_in, Temperature,
    input  SDA_low, Busy, ReadDone, State
  );

  modport slave (
    input  SCL, SDA_in, Temperature,
    output SDA_low, Busy, ReadDone, State
  );
endinterface

// File: rtl/i2c_temp_responder.sv
// I2C read-only target that returns a latched 16-bit temperature word as two bytes.
// Define I2C_RESPONDER_REPEAT_EN to keep streaming the word while the master ACKs byte 2.
module i2c_temp_responder #(
  parameter logic [6:0] ADDRESS     = 7'h4B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   Reset,
  i2c_temp_responder_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AACK, S_TX, S_MACK, S_IGNORE, S_WAITSTOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_d1_q, sda_d1_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_q, byte_d;
  logic [15:0] shift_q, shift_d;
  logic [6:0]  addr_q, addr_d;
  logic        sda_low_q, sda_low_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Synchronizers reset to the idle bus level so release never fakes a START.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d1_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.SCL};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.SDA_in};
      scl_d1_q   <= scl_sync_q[SYNC_STAGES-1];
      sda_d1_q   <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d1_q;
  assign scl_fall  = ~scl_s & scl_d1_q;
  assign start_det = scl_s & scl_d1_q & sda_d1_q & ~sda_s;
  assign stop_det  = scl_s & scl_d1_q & ~sda_d1_q & sda_s;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      byte_q    <= 1'b0;
      shift_q   <= '0;
      addr_q    <= '0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      byte_d    = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            addr_d = {addr_q[5:0], sda_s};
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if ({addr_q, sda_s} == {ADDRESS, 1'b1}) begin
                state_d = S_AACK;
                shift_d = bus.Temperature;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // bit_cnt 0: waiting for the fall that starts the ACK slot; 1: ACK held.
        S_AACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_low_d = 1'b1;
              busy_d    = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              sda_low_d = ~shift_q[15];
              shift_d   = {shift_q[14:0], 1'b0};
              bit_cnt_d = '0;
              state_d   = S_TX;
            end
          end
        end
        S_TX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_MACK;
            end else begin
              sda_low_d = ~shift_q[15];
              shift_d   = {shift_q[14:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // bit_cnt 1 marks a master ACK that continues on the following fall.
        S_MACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = S_WAITSTOP;
              done_d  = byte_q;
            end else if (!byte_q) begin
              bit_cnt_d = 4'd1;
            end else begin
`ifdef I2C_RESPONDER_REPEAT_EN
              done_d    = 1'b1;
              shift_d   = bus.Temperature;
              bit_cnt_d = 4'd1;
`else
              state_d   = S_WAITSTOP;
`endif
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            sda_low_d = ~shift_q[15];
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = '0;
            byte_d    = ~byte_q;
            state_d   = S_TX;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.SDA_low  = sda_low_q;
  assign bus.Busy     = busy_q;
  assign bus.ReadDone = done_q;
  assign bus.State    = state_q;

endmodule

// File: doc/i2c_temp_responder.md
Name: i2c_temp_responder

Overview:
- I2C target (responder) model of the temperature sensor read by our I2C read-temperature controller.
- Watches SCL/SDA, detects START/STOP, matches a 7-bit address with R/W=1, ACKs, then shifts out a 16-bit temperature word MSB-first as two bytes.
- Used as the bus partner for the controller in system simulation and on-board loopback; drives SDA open-drain (pull-low enable only).

Parameters:
- ADDRESS, 7'h4B, 7-bit target address.
- SYNC_STAGES, 2, synchronizer depth for SCL and SDA (min 2).

Ports:
- clock  input  1  system clock; must run at least 8x the SCL rate.
- Reset  input  1  asynchronous, active-high reset.
- SCL  input  1  I2C clock from the controller.
- SDA_in  input  1  resolved SDA bus level.
- Temperature  input  16  sensor value; sampled once per transaction.
- SDA_low  output  1  1 = pull SDA low; 0 = release (bus pull-up).
- Busy  output  1  high from address match until the transaction ends.
- ReadDone  output  1  one-clock pulse when both bytes were sent and the master NACKed the last byte.

Behaviour:
- Sync and edges: SCL and SDA_in each pass through SYNC_STAGES flops. Edge detection uses the synchronized value and its one-cycle-delayed copy. All decisions use synchronized signals only.
- START: SDA falls while SCL is high. Accepted in any state, including mid-byte (repeated START). Effect: go to ADDR, clear the bit counter, release SDA.
- STOP: SDA rises while SCL is high. Effect: go to IDLE from any state, release SDA, clear Busy.
- Sampling and driving: input bits are sampled on SCL rising edges. SDA_low changes only on SCL falling edges, registered one clock after the falling edge is detected. The next bit is therefore valid before the next SCL rise.
- States:
  - IDLE: SDA released, waiting for START.
  - ADDR: shift 8 bits (7-bit address then R/W). After the 8th rising edge:
    - address == ADDRESS and R/W=1: go to AACK and latch Temperature into a 16-bit shift register.
    - otherwise: go to IGNORE.
  - AACK: on the next SCL fall, SDA_low=1 and Busy=1. Hold through the 9th clock. On the 9th clock's fall, drive bit 15 and go to TX.
  - TX: 8 bits per byte, updated on each SCL fall. After the 8th bit's fall, release SDA and go to MACK.
  - MACK: sample SDA on the SCL rise.
    - 0 (ACK) after byte 1: on the fall, drive bit 7 and return to TX for byte 2.
    - 0 (ACK) after byte 2: see Optional Feature.
    - 1 (NACK) after byte 2: pulse ReadDone, go to WAITSTOP.
    - 1 (NACK) after byte 1: go to WAITSTOP with no ReadDone.
  - IGNORE / WAITSTOP: SDA released; only START or STOP is acted on.
- Counters: 4-bit bit counter, 1-bit byte index. Wrap to 0 on every START.
- Reset values: state IDLE, SDA_low=0, Busy=0, ReadDone=0, shift register 0, counters 0.
- Reset mid-transaction: immediate release of SDA. A subsequent STOP or START from the master is handled normally.
- Temperature changing mid-transaction has no effect; only the value latched at the address match is sent.
- A START arriving while this block holds SDA low is not detectable (the bus stays low). This is acceptable per protocol.

Optional Feature:
- Macro: I2C_RESPONDER_REPEAT_EN.
- Defined: master ACK after byte 2 re-latches Temperature and continues with byte 1 (continuous read). ReadDone pulses after every completed byte-2 regardless of the ACK value.
- Undefined: master ACK after byte 2 goes to WAITSTOP with SDA released. ReadDone pulses only on NACK after byte 2.

Test Plan:
- Reset: assert Reset for 3 clocks mid-ADDR -> SDA_low=0, Busy=0, ReadDone=0 within the same cycle. After release, the block waits for a START.
- Matching read: START, address 0x4B+R (byte 0x97), Temperature=16'h1A5C -> ACK on the 9th clock. Master samples 0x1A, ACK, then 0x5C. Master NACK then STOP -> one ReadDone pulse, Busy low after STOP.
- Wrong address / write: bytes 0x91 and 0x96 -> SDA never driven, Busy stays 0, no ReadDone.
- Early NACK: master NACKs after 0x1A -> SDA released, no ReadDone, STOP returns the block to IDLE.
- Repeated START mid-byte 2, then a new 0x97 read with Temperature=16'h0080 -> fresh ACK, bytes 0x00 then 0x80 sent.
- Macro defined: master ACKs after byte 2 -> bytes 0x1A, 0x5C, 0x1A, 0x5C in sequence, two ReadDone pulses. Macro undefined: SDA released after the second byte.
